// File: rtl/branch_cond_unit.sv
// Branch-condition unit: architectural {Z,C,V,S} flag register, 16-code condition
// evaluator with registered result, and a LIFO flag save/restore stack.
module branch_cond_unit #(
   parameter int STACK_DEPTH = 4,
   parameter bit BYPASS      = 1'b1,
   localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flag_we,
   input  logic          zero_in,
   input  logic          carry_in,
   input  logic          overflow_in,
   input  logic          minus_in,
   input  logic          eval,
   input  logic [3:0]    cond,
   output logic          taken,
   output logic          taken_valid,
   input  logic          push,
   input  logic          pop,
   output logic [3:0]    flags,
   output logic [DW-1:0] stk_depth,
   output logic          stk_full,
   output logic          stk_empty,
   output logic          stk_err
);

   localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [3:0]    r_flags;
   logic [3:0]    r_stack [STACK_DEPTH];
   logic [DW-1:0] r_depth;
   logic          r_full;
   logic          r_empty;
   logic          r_taken;
   logic          r_taken_valid;
   logic          r_err;

   logic          w_push_ok;
   logic          w_pop_ok;
   logic          w_err;
   logic [DW-1:0] w_depth_nxt;
   logic [DW-1:0] w_depth_m1;
   logic [3:0]    w_flags_nxt;
   logic [3:0]    w_operand;
   logic [IW-1:0] w_wr_idx;
   logic [IW-1:0] w_rd_idx;

   // Flag word layout is {Z,C,V,S}; N is the signed "less than" S^V.
   function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
      logic z, cy, v, s, n;
      z  = f[3];
      cy = f[2];
      v  = f[1];
      s  = f[0];
      n  = s ^ v;
      case (c)
         4'd0:    eval_cond = z;
         4'd1:    eval_cond = n;
         4'd2:    eval_cond = z | n;
         4'd3:    eval_cond = ~z;
         4'd4:    eval_cond = ~n;
         4'd5:    eval_cond = ~z & ~n;
         4'd6:    eval_cond = cy;
         4'd7:    eval_cond = ~cy;
         4'd8:    eval_cond = cy & ~z;
         4'd9:    eval_cond = ~cy | z;
         4'd10:   eval_cond = s;
         4'd11:   eval_cond = ~s;
         4'd12:   eval_cond = v;
         4'd13:   eval_cond = ~v;
         4'd14:   eval_cond = 1'b1;
         4'd15:   eval_cond = 1'b0;
         default: eval_cond = 1'b0;
      endcase
   endfunction

   assign w_depth_m1 = r_depth - DW'(1);
   assign w_wr_idx   = r_depth[IW-1:0];
   assign w_rd_idx   = w_depth_m1[IW-1:0];

   // Stack request legality, next depth, next flags and eval operand.
   always_comb begin
      w_push_ok   = 1'b0;
      w_pop_ok    = 1'b0;
      w_err       = 1'b0;
      w_depth_nxt = r_depth;
      w_flags_nxt = r_flags;
      w_operand   = r_flags;
      if (push && pop) begin
         w_err = 1'b1;
      end else if (push) begin
         if (r_full) begin
            w_err = 1'b1;
         end else begin
            w_push_ok   = 1'b1;
            w_depth_nxt = r_depth + DW'(1);
         end
      end else if (pop) begin
         if (r_empty) begin
            w_err = 1'b1;
         end else begin
            w_pop_ok    = 1'b1;
            w_depth_nxt = w_depth_m1;
         end
      end else begin
         w_err = 1'b0;
      end
      // A legal pop outranks a same-cycle ALU flag load.
      if (w_pop_ok) begin
         w_flags_nxt = r_stack[w_rd_idx];
      end else if (flag_we) begin
         w_flags_nxt = {zero_in, carry_in, overflow_in, minus_in};
      end else begin
         w_flags_nxt = r_flags;
      end
      if (BYPASS) begin
         w_operand = w_flags_nxt;
      end else begin
         w_operand = r_flags;
      end
   end

   // Flag register, stack bookkeeping and registered evaluation result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags       <= 4'h0;
         r_depth       <= {DW{1'b0}};
         r_full        <= 1'b0;
         r_empty       <= 1'b1;
         r_taken       <= 1'b0;
         r_taken_valid <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_flags       <= w_flags_nxt;
         r_depth       <= w_depth_nxt;
         r_full        <= (w_depth_nxt == DW'(STACK_DEPTH));
         r_empty       <= (w_depth_nxt == {DW{1'b0}});
         r_taken_valid <= eval;
         r_err         <= w_err;
         if (eval) begin
            r_taken <= eval_cond(cond, w_operand);
         end
      end
   end

   // Stack storage is deliberately not reset; depth alone defines validity.
   always_ff @(posedge clk) begin
      if (w_push_ok && !rst) begin
         r_stack[w_wr_idx] <= r_flags;
      end
   end

   assign flags       = r_flags;
   assign stk_depth   = r_depth;
   assign stk_full    = r_full;
   assign stk_empty   = r_empty;
   assign stk_err     = r_err;
   assign taken       = r_taken;
   assign taken_valid = r_taken_valid;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed self-checking bench for branch_cond_unit; a BYPASS=1 and a BYPASS=0
// instance share all inputs so bypass behaviour can be compared directly.
module tb_branch_cond_unit;

   logic       clk = 1'b0;
   logic       rst, flag_we, zero_in, carry_in, overflow_in, minus_in;
   logic       eval, push, pop;
   logic [3:0] cond;

   logic       taken, taken_valid, stk_full, stk_empty, stk_err;
   logic [3:0] flags;
   logic [2:0] stk_depth;
   logic       taken0, taken_valid0, stk_full0, stk_empty0, stk_err0;
   logic [3:0] flags0;
   logic [2:0] stk_depth0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   branch_cond_unit #(.STACK_DEPTH(4), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .flag_we(flag_we), .zero_in(zero_in), .carry_in(carry_in),
      .overflow_in(overflow_in), .minus_in(minus_in), .eval(eval), .cond(cond),
      .taken(taken), .taken_valid(taken_valid), .push(push), .pop(pop), .flags(flags),
      .stk_depth(stk_depth), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
   );

   branch_cond_unit #(.STACK_DEPTH(4), .BYPASS(1'b0)) dut0 (
      .clk(clk), .rst(rst), .flag_we(flag_we), .zero_in(zero_in), .carry_in(carry_in),
      .overflow_in(overflow_in), .minus_in(minus_in), .eval(eval), .cond(cond),
      .taken(taken0), .taken_valid(taken_valid0), .push(push), .pop(pop), .flags(flags0),
      .stk_depth(stk_depth0), .stk_full(stk_full0), .stk_empty(stk_empty0), .stk_err(stk_err0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] f);
      {zero_in, carry_in, overflow_in, minus_in} = f;
   endtask

   task automatic idle();
      flag_we = 1'b0; eval = 1'b0; push = 1'b0; pop = 1'b0; rst = 1'b0;
   endtask

   task automatic load(input logic [3:0] f);
      flag_we = 1'b1; set_in(f); tick(); idle();
   endtask

   task automatic do_eval(input string tag, input logic [3:0] c, input logic exp1, input logic exp0);
      eval = 1'b1; cond = c; tick(); idle();
      check({tag, "_taken"}, taken, exp1);
      check({tag, "_taken_nobyp"}, taken0, exp0);
      check({tag, "_valid"}, taken_valid, 1'b1);
   endtask

   task automatic do_reset();
      idle(); rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic check_stack(input string tag, input logic [3:0] f, input logic [2:0] d,
                              input logic e);
      check({tag, "_flags"}, flags, f);
      check({tag, "_depth"}, stk_depth, d);
      check({tag, "_full"}, stk_full, (d == 3'd4));
      check({tag, "_empty"}, stk_empty, (d == 3'd0));
      check({tag, "_err"}, stk_err, e);
   endtask

   // Spec condition table as a lookup vector indexed by the code.
   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic z, cy, v, s, n;
      logic [15:0] lut;
      z = f[3]; cy = f[2]; v = f[1]; s = f[0]; n = s ^ v;
      lut = {1'b0, 1'b1, ~v, v, ~s, s, (~cy | z), (cy & ~z), ~cy, cy,
             (~z & ~n), ~n, ~z, (z | n), n, z};
      return lut[c];
   endfunction

   initial begin
      idle(); cond = 4'd0; set_in(4'h0);
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      check_stack("reset", 4'h0, 3'd0, 1'b0);
      check("reset_taken", taken, 1'b0);
      check("reset_valid", taken_valid, 1'b0);

      // Basic EQ/NE and taken hold
      load(4'b1000);
      do_eval("t1_eq", 4'd0, 1'b1, 1'b1);
      do_eval("t1_ne", 4'd3, 1'b0, 1'b0);
      do_eval("t1_al", 4'd14, 1'b1, 1'b1);
      tick();
      check("t1_hold_valid", taken_valid, 1'b0);
      check("t1_hold_taken", taken, 1'b1);

      // Signed compares
      load(4'b0001);
      do_eval("t2a_lt", 4'd1, 1'b1, 1'b1);
      do_eval("t2a_le", 4'd2, 1'b1, 1'b1);
      do_eval("t2a_ge", 4'd4, 1'b0, 1'b0);
      do_eval("t2a_gt", 4'd5, 1'b0, 1'b0);
      load(4'b0011);
      do_eval("t2b_lt", 4'd1, 1'b0, 1'b0);
      do_eval("t2b_le", 4'd2, 1'b0, 1'b0);
      do_eval("t2b_ge", 4'd4, 1'b1, 1'b1);
      do_eval("t2b_gt", 4'd5, 1'b1, 1'b1);
      load(4'b1011);
      do_eval("t2c_le", 4'd2, 1'b1, 1'b1);
      do_eval("t2c_gt", 4'd5, 1'b0, 1'b0);

      // Full sweep of codes against flag combinations
      for (int f = 0; f < 16; f++) begin
         load(f[3:0]);
         for (int c = 0; c < 16; c++) begin
            eval = 1'b1; cond = c[3:0]; tick(); idle();
            if (taken !== ref_cond(c[3:0], f[3:0]))
               $display("sweep detail: cond=%0d flags=%0h", c, f);
            check("t2_sweep", taken, ref_cond(c[3:0], f[3:0]));
         end
      end

      // Same-cycle flag load with eval: bypass vs registered operand
      do_reset();
      flag_we = 1'b1; set_in(4'b1000); eval = 1'b1; cond = 4'd0; tick(); idle();
      check("t3_byp", taken, 1'b1);
      check("t3_nobyp", taken0, 1'b0);

      // Fill, overflow, drain, underflow
      do_reset();
      load(4'h1);
      push = 1'b1; flag_we = 1'b1; set_in(4'h2); tick(); idle();
      push = 1'b1; flag_we = 1'b1; set_in(4'h3); tick(); idle();
      push = 1'b1; flag_we = 1'b1; set_in(4'h4); tick(); idle();
      push = 1'b1; tick(); idle();
      check_stack("t4_full", 4'h4, 3'd4, 1'b0);
      push = 1'b1; flag_we = 1'b1; set_in(4'h7); tick(); idle();
      check_stack("t4_ovf", 4'h7, 3'd4, 1'b1);
      pop = 1'b1; tick(); idle();
      check_stack("t4_pop4", 4'h4, 3'd3, 1'b0);
      pop = 1'b1; tick(); idle();
      check_stack("t4_pop3", 4'h3, 3'd2, 1'b0);
      pop = 1'b1; tick(); idle();
      check_stack("t4_pop2", 4'h2, 3'd1, 1'b0);
      pop = 1'b1; tick(); idle();
      check_stack("t4_pop1", 4'h1, 3'd0, 1'b0);
      pop = 1'b1; tick(); idle();
      check_stack("t4_unf", 4'h1, 3'd0, 1'b1);
      tick();
      check("t4_err_pulse", stk_err, 1'b0);

      // Push/pop combined with flag_we
      load(4'h5);
      push = 1'b1; flag_we = 1'b1; set_in(4'hA); tick(); idle();
      check_stack("t5_push", 4'hA, 3'd1, 1'b0);
      pop = 1'b1; flag_we = 1'b1; set_in(4'h3); tick(); idle();
      check_stack("t5_pop", 4'h5, 3'd0, 1'b0);
      load(4'b1000);
      push = 1'b1; flag_we = 1'b1; set_in(4'b0000); tick(); idle();
      pop = 1'b1; eval = 1'b1; cond = 4'd0; tick(); idle();
      check("t5_popbyp", taken, 1'b1);
      check("t5_popnobyp", taken0, 1'b0);
      check("t5_popflags", flags0, 4'b1000);

      // Simultaneous push&pop, then reset mid-sequence
      do_reset();
      load(4'h1);
      push = 1'b1; flag_we = 1'b1; set_in(4'h2); tick(); idle();
      push = 1'b1; flag_we = 1'b1; set_in(4'h3); tick(); idle();
      push = 1'b1; pop = 1'b1; tick(); idle();
      check_stack("t6_pp", 4'h3, 3'd2, 1'b1);
      eval = 1'b1; cond = 4'd14; tick(); idle();
      check("t6_pre_taken", taken, 1'b1);
      rst = 1'b1; push = 1'b1; eval = 1'b1; flag_we = 1'b1; set_in(4'hF); tick(); idle();
      check_stack("t6_rst", 4'h0, 3'd0, 1'b0);
      check("t6_rst_taken", taken, 1'b0);
      check("t6_rst_valid", taken_valid, 1'b0);
      pop = 1'b1; tick(); idle();
      check_stack("t6_unreach", 4'h0, 3'd0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
